// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder interface: Gray state codes,
// signed step encoding and the 4x decode helpers.
package enc_pkg;

    localparam logic [1:0] GRAY_S0 = 2'b00;
    localparam logic [1:0] GRAY_S1 = 2'b01;
    localparam logic [1:0] GRAY_S2 = 2'b11;
    localparam logic [1:0] GRAY_S3 = 2'b10;

    typedef logic signed [1:0] step_t;

    localparam step_t STEP_NONE = 2'sb00;
    localparam step_t STEP_FWD  = 2'sb01;
    localparam step_t STEP_REV  = 2'sb11;

    // Successor of a state along the forward rotation.
    function automatic logic [1:0] gray_next(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            GRAY_S0: n = GRAY_S1;
            GRAY_S1: n = GRAY_S2;
            GRAY_S2: n = GRAY_S3;
            GRAY_S3: n = GRAY_S0;
            default: n = GRAY_S0;
        endcase
        return n;
    endfunction

    // Double-bit changes map to STEP_NONE; the caller flags them separately.
    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t s;
        if (cur == prev) begin
            s = STEP_NONE;
        end else if (cur == gray_next(prev)) begin
            s = STEP_FWD;
        end else if (prev == gray_next(cur)) begin
            s = STEP_REV;
        end else begin
            s = STEP_NONE;
        end
        return s;
    endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// One encoder channel: two-flop synchroniser followed by a stability filter
// that only passes a new level after FILT_LEN consecutive differing samples.
module enc_glitch_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic cloc,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;
    logic          dout_r;

    // Synchroniser chain for the asynchronous pin.
    always_ff @(posedge cloc) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter; any return to the filtered level restarts it.
    always_ff @(posedge cloc) begin
        if (rst) begin
            cnt_r  <= {CW{1'b0}};
            dout_r <= 1'b0;
        end else if (sync2_r == dout_r) begin
            cnt_r  <= {CW{1'b0}};
            dout_r <= dout_r;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= {CW{1'b0}};
            dout_r <= sync2_r;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            dout_r <= dout_r;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/quad_enc_counter.sv
// Quadrature encoder interface: filtered A/B, 4x decode, position counter,
// windowed signed velocity, direction and sticky illegal-transition flag.
module quad_enc_counter
    import enc_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int VEL_W    = 12,
    parameter int FILT_LEN = 4,
    parameter int WIN_CYC  = 1000,
    parameter int SATURATE = 0
) (
    input  logic             cloc,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             pos_clr,
    input  logic             err_clr,
    output logic [CNT_W-1:0] pos,
    output logic [VEL_W-1:0] vel,
    output logic             vel_valid,
    output logic             dir,
    output logic             err
);

    localparam int AW  = VEL_W + 2;
    localparam int WCW = $clog2(WIN_CYC);
    localparam logic [WCW-1:0]   WIN_LAST = WCW'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] POS_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] POS_MIN  = {CNT_W{1'b0}};
    localparam logic signed [AW:0] ACC_MAX = {2'b00, {(AW-1){1'b1}}};
    localparam logic signed [AW:0] ACC_MIN = {2'b11, {(AW-1){1'b0}}};
    localparam logic signed [AW:0] VEL_MAX = {{(AW-VEL_W+2){1'b0}}, {(VEL_W-1){1'b1}}};
    localparam logic signed [AW:0] VEL_MIN = {{(AW-VEL_W+2){1'b1}}, {(VEL_W-1){1'b0}}};

    logic              a_filt_s;
    logic              b_filt_s;
    logic [1:0]        ab_s;
    step_t             step_s;
    logic              illegal_s;
    logic signed [AW:0] sum_s;
    logic [AW-1:0]     acc_nxt_s;
    logic [VEL_W-1:0]  vel_nxt_s;

    logic [1:0]        prev_r;
    logic [CNT_W-1:0]  pos_r;
    logic              dir_r;
    logic              err_r;
    logic [WCW-1:0]    wcnt_r;
    logic [AW-1:0]     acc_r;
    logic [VEL_W-1:0]  vel_r;
    logic              vel_valid_r;

    enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .cloc (cloc),
        .rst  (rst),
        .din  (enc_a),
        .dout (a_filt_s)
    );

    enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .cloc (cloc),
        .rst  (rst),
        .din  (enc_b),
        .dout (b_filt_s)
    );

    // Step decode against the previous filtered state.
    always_comb begin
        ab_s      = {a_filt_s, b_filt_s};
        step_s    = decode_step(prev_r, ab_s);
        illegal_s = ((prev_r ^ ab_s) == 2'b11);
    end

    // Accumulator update and velocity sample, both clamped; sum is one bit wider to see overflow.
    always_comb begin
        sum_s = {acc_r[AW-1], acc_r} + {{(AW-1){step_s[1]}}, step_s};
        if (sum_s > ACC_MAX) begin
            acc_nxt_s = ACC_MAX[AW-1:0];
        end else if (sum_s < ACC_MIN) begin
            acc_nxt_s = ACC_MIN[AW-1:0];
        end else begin
            acc_nxt_s = sum_s[AW-1:0];
        end
        if (sum_s > VEL_MAX) begin
            vel_nxt_s = VEL_MAX[VEL_W-1:0];
        end else if (sum_s < VEL_MIN) begin
            vel_nxt_s = VEL_MIN[VEL_W-1:0];
        end else begin
            vel_nxt_s = sum_s[VEL_W-1:0];
        end
    end

    // Previous-state register, direction and sticky error (a new fault beats err_clr).
    always_ff @(posedge cloc) begin
        if (rst) begin
            prev_r <= 2'b00;
            dir_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            prev_r <= ab_s;
            if (step_s == STEP_FWD) begin
                dir_r <= 1'b1;
            end else if (step_s == STEP_REV) begin
                dir_r <= 1'b0;
            end else begin
                dir_r <= dir_r;
            end
            if (illegal_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Position counter; pos_clr drops a coincident step from pos only.
    always_ff @(posedge cloc) begin
        if (rst) begin
            pos_r <= POS_MIN;
        end else if (pos_clr) begin
            pos_r <= POS_MIN;
        end else if (step_s == STEP_FWD) begin
            if ((SATURATE != 0) && (pos_r == POS_MAX)) begin
                pos_r <= pos_r;
            end else begin
                pos_r <= pos_r + CNT_W'(1);
            end
        end else if (step_s == STEP_REV) begin
            if ((SATURATE != 0) && (pos_r == POS_MIN)) begin
                pos_r <= pos_r;
            end else begin
                pos_r <= pos_r - CNT_W'(1);
            end
        end else begin
            pos_r <= pos_r;
        end
    end

    // Free-running velocity window; the last cycle's step lands in the published sample.
    always_ff @(posedge cloc) begin
        if (rst) begin
            wcnt_r      <= {WCW{1'b0}};
            acc_r       <= {AW{1'b0}};
            vel_r       <= {VEL_W{1'b0}};
            vel_valid_r <= 1'b0;
        end else if (wcnt_r == WIN_LAST) begin
            wcnt_r      <= {WCW{1'b0}};
            acc_r       <= {AW{1'b0}};
            vel_r       <= vel_nxt_s;
            vel_valid_r <= 1'b1;
        end else begin
            wcnt_r      <= wcnt_r + WCW'(1);
            acc_r       <= acc_nxt_s;
            vel_r       <= vel_r;
            vel_valid_r <= 1'b0;
        end
    end

    assign pos       = pos_r;
    assign vel       = vel_r;
    assign vel_valid = vel_valid_r;
    assign dir       = dir_r;
    assign err       = err_r;

endmodule

// File: tb/tb_quad_enc_counter.sv
// Directed bench: default wrap instance, 8-bit saturating instance and a
// long-window velocity instance, all checked against hand-computed values.
module tb_quad_enc_counter;

    logic cloc = 1'b0;
    logic rst  = 1'b1;
    logic [1:0] ab [3];
    logic pos_clr0 = 1'b0, err_clr0 = 1'b0;
    logic pos_clr1 = 1'b0, err_clr1 = 1'b0;
    logic pos_clr2 = 1'b0, err_clr2 = 1'b0;

    logic [15:0] pos0, pos2;
    logic [7:0]  pos1;
    logic [11:0] vel0, vel1, vel2;
    logic vv0, vv1, vv2, dir0, dir1, dir2, err0, err1, err2;

    int tests = 0;
    int fails = 0;

    always #5 cloc = ~cloc;

    quad_enc_counter u_def (
        .cloc(cloc), .rst(rst), .enc_a(ab[0][1]), .enc_b(ab[0][0]),
        .pos_clr(pos_clr0), .err_clr(err_clr0),
        .pos(pos0), .vel(vel0), .vel_valid(vv0), .dir(dir0), .err(err0)
    );

    quad_enc_counter #(.CNT_W(8), .FILT_LEN(1), .SATURATE(1)) u_sat (
        .cloc(cloc), .rst(rst), .enc_a(ab[1][1]), .enc_b(ab[1][0]),
        .pos_clr(pos_clr1), .err_clr(err_clr1),
        .pos(pos1), .vel(vel1), .vel_valid(vv1), .dir(dir1), .err(err1)
    );

    quad_enc_counter #(.FILT_LEN(1), .WIN_CYC(3000)) u_vel (
        .cloc(cloc), .rst(rst), .enc_a(ab[2][1]), .enc_b(ab[2][0]),
        .pos_clr(pos_clr2), .err_clr(err_clr2),
        .pos(pos2), .vel(vel2), .vel_valid(vv2), .dir(dir2), .err(err2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cloc);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [1:0] fwd_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic fwd(input int inst, input int n, input int hold);
        repeat (n) begin
            ab[inst] = fwd_of(ab[inst]);
            tick(hold);
        end
    endtask

    task automatic rev(input int inst, input int n, input int hold);
        repeat (n) begin
            ab[inst] = rev_of(ab[inst]);
            tick(hold);
        end
    endtask

    task automatic wait_vel();
        int n = 0;
        while (vv2 !== 1'b1 && n < 3100) begin
            tick(1);
            n++;
        end
        chk("vel_valid_seen", {31'd0, vv2}, 32'd1);
    endtask

    initial begin
        ab[0] = 2'b00;
        ab[1] = 2'b00;
        ab[2] = 2'b00;
        tick(3);
        chk("rst_pos",   {16'd0, pos0}, 32'd0);
        chk("rst_vel",   {20'd0, vel0}, 32'd0);
        chk("rst_vv",    {31'd0, vv0},  32'd0);
        chk("rst_dir",   {31'd0, dir0}, 32'd0);
        chk("rst_err",   {31'd0, err0}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Latency: first pos change on the 7th edge after the pin change.
        ab[0] = 2'b01;
        tick(6);
        chk("lat_edge6", {16'd0, pos0}, 32'd0);
        tick(1);
        chk("lat_edge7", {16'd0, pos0}, 32'd1);
        tick(3);
        fwd(0, 31, 10);
        chk("fwd32_pos", {16'd0, pos0}, 32'd32);
        chk("fwd32_dir", {31'd0, dir0}, 32'd1);
        chk("fwd32_err", {31'd0, err0}, 32'd0);

        // 3-cycle glitch on A must be filtered out.
        ab[0][1] = 1'b1;
        tick(3);
        ab[0][1] = 1'b0;
        tick(10);
        chk("glitch_pos", {16'd0, pos0}, 32'd32);
        chk("glitch_err", {31'd0, err0}, 32'd0);

        // Illegal 00->11, clear, then clear coincident with a new illegal step.
        ab[0] = 2'b11;
        tick(10);
        chk("ill_err", {31'd0, err0}, 32'd1);
        chk("ill_pos", {16'd0, pos0}, 32'd32);
        err_clr0 = 1'b1;
        tick(1);
        err_clr0 = 1'b0;
        chk("errclr", {31'd0, err0}, 32'd0);
        ab[0] = 2'b00;
        tick(6);
        chk("ill2_pre", {31'd0, err0}, 32'd0);
        err_clr0 = 1'b1;
        tick(1);
        err_clr0 = 1'b0;
        chk("ill2_setwins", {31'd0, err0}, 32'd1);
        tick(4);

        // Wrap mode at both limits.
        pos_clr0 = 1'b1;
        tick(1);
        pos_clr0 = 1'b0;
        chk("posclr", {16'd0, pos0}, 32'd0);
        rev(0, 1, 10);
        chk("wrap_rev_pos", {16'd0, pos0}, 32'd65535);
        chk("wrap_rev_dir", {31'd0, dir0}, 32'd0);
        fwd(0, 1, 10);
        chk("wrap_fwd_pos", {16'd0, pos0}, 32'd0);
        chk("wrap_fwd_dir", {31'd0, dir0}, 32'd1);

        // Saturating 8-bit instance.
        rev(1, 1, 3);
        tick(4);
        chk("sat_lo_pos", {24'd0, pos1}, 32'd0);
        chk("sat_lo_dir", {31'd0, dir1}, 32'd0);
        fwd(1, 255, 2);
        tick(4);
        chk("sat_255", {24'd0, pos1}, 32'd255);
        fwd(1, 1, 3);
        tick(4);
        chk("sat_hi_pos", {24'd0, pos1}, 32'd255);
        chk("sat_hi_dir", {31'd0, dir1}, 32'd1);

        // Velocity: window with pos_clr on the 11th step.
        wait_vel();
        fwd(2, 10, 2);
        tick(4);
        chk("vel_pos10", {16'd0, pos2}, 32'd10);
        ab[2] = fwd_of(ab[2]);
        tick(3);
        pos_clr2 = 1'b1;
        tick(1);
        pos_clr2 = 1'b0;
        chk("clr_step_pos", {16'd0, pos2}, 32'd0);
        chk("clr_step_dir", {31'd0, dir2}, 32'd1);
        wait_vel();
        chk("vel_11", {20'd0, vel2}, 32'd11);
        tick(1);
        chk("vv_one_cycle", {31'd0, vv2}, 32'd0);

        // 40 reverse steps in one window.
        rev(2, 40, 2);
        tick(4);
        chk("rev40_pos", {16'd0, pos2}, 32'd65496);
        wait_vel();
        chk("vel_m40", {20'd0, vel2}, 32'h0000_0FD8);

        // 2100 forward steps clamp to the 12-bit maximum.
        fwd(2, 2100, 1);
        wait_vel();
        chk("vel_clamp", {20'd0, vel2}, 32'h0000_07FF);

        // Reset mid-operation.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mrst_pos", {16'd0, pos2}, 32'd0);
        chk("mrst_vel", {20'd0, vel2}, 32'd0);
        chk("mrst_dir", {31'd0, dir2}, 32'd0);
        chk("mrst_err", {31'd0, err0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
